// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back/commit stage: FSM encoding,
// write-back source selectors and flag-register bit positions.
package wb_stage_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    COMMIT   = 2'd2
  } state_t;

  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_DM    = 2'd1;
  localparam logic [1:0] WB_LINK  = 2'd2;
  localparam logic [1:0] WB_CONST = 2'd3;

  localparam int FLAG_O = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  // Data-memory results arrive a cycle late, so only register writes sourced
  // from dm_Q need the extra wait state.
  function automatic logic needs_mem_wait(input logic w_rb, input logic [1:0] sel);
    return w_rb && (sel == WB_DM);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Execute-to-write-back bus: the per-instruction control and data fields
// plus the valid/ready handshake.
interface wb_stage_if #(
  parameter int PC_W  = 32,
  parameter int RB_AW = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             uc_W_RB;
  logic [1:0]       uc_S_MXWB;
  logic [3:0]       uc_W_FLAGS;
  logic             uc_JUMP;
  logic [RB_AW-1:0] rd_addr;
  logic [31:0]      alu_result;
  logic             alu_O;
  logic             alu_S;
  logic             alu_C;
  logic             alu_Z;
  logic [31:0]      dm_Q;
  logic [31:0]      se_out;
  logic [PC_W-1:0]  pc_link;
  logic             tf_out;

  modport master (
    output in_valid, uc_W_RB, uc_S_MXWB, uc_W_FLAGS, uc_JUMP, rd_addr,
           alu_result, alu_O, alu_S, alu_C, alu_Z, dm_Q, se_out, pc_link, tf_out,
    input  in_ready
  );

  modport slave (
    input  in_valid, uc_W_RB, uc_S_MXWB, uc_W_FLAGS, uc_JUMP, rd_addr,
           alu_result, alu_O, alu_S, alu_C, alu_Z, dm_Q, se_out, pc_link, tf_out,
    output in_ready
  );
endinterface

// File: rtl/wb_stage_mx_wb.sv
// Combinational 4:1 selector choosing the value written back to the
// register bank.
module mx_wb
  import wb_stage_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [31:0] alu_val,
  input  logic [31:0] dm_val,
  input  logic [31:0] link_val,
  input  logic [31:0] se_val,
  output logic [31:0] data
);

  always_comb begin
    data = alu_val;
    case (sel)
      WB_ALU:   data = alu_val;
      WB_DM:    data = dm_val;
      WB_LINK:  data = link_val;
      WB_CONST: data = se_val;
      default:  data = alu_val;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back and commit stage: latches one execute-stage instruction, waits
// for load data when needed, then drives the register-bank write port,
// the flag register, the PC-load request and the retired counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int RB_AW = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  wb_stage_if.slave        ex,
  output logic             rf_O,
  output logic             rf_S,
  output logic             rf_C,
  output logic             rf_Z,
  output logic             rb_W,
  output logic [RB_AW-1:0] rb_ADDR,
  output logic [31:0]      rb_DATA,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_target,
  output logic [31:0]      retired
);

  state_t state, state_next;
  logic capture, capture_dm, commit;

  logic             w_rb_q, jump_q, tf_q;
  logic [1:0]       sel_q;
  logic [3:0]       wflags_q, aflags_q;
  logic [RB_AW-1:0] rd_q;
  logic [31:0]      alu_q, se_q, dm_q;
  logic [PC_W-1:0]  link_q;

  logic [3:0]       flags_q;
  logic [RB_AW-1:0] hold_addr;
  logic [31:0]      hold_data;
  logic [PC_W-1:0]  hold_target;
  logic [31:0]      retired_q;
  logic [31:0]      wb_data;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    capture_dm = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (ex.in_valid) begin
          capture    = 1'b1;
          state_next = needs_mem_wait(ex.uc_W_RB, ex.uc_S_MXWB) ? MEM_WAIT : COMMIT;
        end
      end
      MEM_WAIT: begin
        capture_dm = 1'b1;
        state_next = COMMIT;
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ex.in_ready = (state == IDLE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      w_rb_q   <= 1'b0;
      jump_q   <= 1'b0;
      tf_q     <= 1'b0;
      sel_q    <= WB_ALU;
      wflags_q <= '0;
      aflags_q <= '0;
      rd_q     <= '0;
      alu_q    <= '0;
      se_q     <= '0;
      link_q   <= '0;
      dm_q     <= '0;
    end else begin
      if (capture) begin
        w_rb_q   <= ex.uc_W_RB;
        jump_q   <= ex.uc_JUMP;
        tf_q     <= ex.tf_out;
        sel_q    <= ex.uc_S_MXWB;
        wflags_q <= ex.uc_W_FLAGS;
        aflags_q <= {ex.alu_O, ex.alu_S, ex.alu_C, ex.alu_Z};
        rd_q     <= ex.rd_addr;
        alu_q    <= ex.alu_result;
        se_q     <= ex.se_out;
        link_q   <= ex.pc_link;
      end
      if (capture_dm) dm_q <= ex.dm_Q;
    end
  end

  mx_wb u_mx_wb (
    .sel      (sel_q),
    .alu_val  (alu_q),
    .dm_val   (dm_q),
    .link_val (32'(link_q)),
    .se_val   (se_q),
    .data     (wb_data)
  );

  // Flags, held outputs and the retire count all change on the edge that
  // leaves COMMIT, so a flag test during commit still sees the old flags.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flags_q     <= '0;
      hold_addr   <= '0;
      hold_data   <= '0;
      hold_target <= '0;
      retired_q   <= '0;
    end else if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wflags_q[i]) flags_q[i] <= aflags_q[i];
      end
      hold_addr   <= rd_q;
      hold_data   <= wb_data;
      hold_target <= alu_q[PC_W-1:0];
      retired_q   <= retired_q + 32'd1;
    end
  end

  assign rb_W      = commit & w_rb_q;
  assign pc_load   = commit & jump_q & tf_q;
  assign rb_ADDR   = commit ? rd_q : hold_addr;
  assign rb_DATA   = commit ? wb_data : hold_data;
  assign pc_target = commit ? alu_q[PC_W-1:0] : hold_target;
  assign retired   = retired_q;

  assign rf_O = flags_q[FLAG_O];
  assign rf_S = flags_q[FLAG_S];
  assign rf_C = flags_q[FLAG_C];
  assign rf_Z = flags_q[FLAG_Z];

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: hand-computed vectors for ALU, load,
// jump/link, flag isolation, reset during MEM_WAIT and retired wrap.
module tb_wb_stage;

  logic        CLK;
  logic        RESET;
  logic        rf_O, rf_S, rf_C, rf_Z;
  logic        rb_W;
  logic [4:0]  rb_ADDR;
  logic [31:0] rb_DATA;
  logic        pc_load;
  logic [31:0] pc_target;
  logic [31:0] retired;

  int checkCount = 0;
  int errorCount = 0;

  wb_stage_if #(.PC_W(32), .RB_AW(5)) ex_bus ();

  wb_stage #(.PC_W(32), .RB_AW(5)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ex        (ex_bus.slave),
    .rf_O      (rf_O),
    .rf_S      (rf_S),
    .rf_C      (rf_C),
    .rf_Z      (rf_Z),
    .rb_W      (rb_W),
    .rb_ADDR   (rb_ADDR),
    .rb_DATA   (rb_DATA),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .retired   (retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic w_rb, input logic [1:0] sel,
                               input logic [3:0] wflags, input logic jump,
                               input logic [4:0] rd, input logic [31:0] alu,
                               input logic [3:0] aflags, input logic [31:0] se,
                               input logic [31:0] link, input logic tf);
    ex_bus.in_valid   = 1'b1;
    ex_bus.uc_W_RB    = w_rb;
    ex_bus.uc_S_MXWB  = sel;
    ex_bus.uc_W_FLAGS = wflags;
    ex_bus.uc_JUMP    = jump;
    ex_bus.rd_addr    = rd;
    ex_bus.alu_result = alu;
    {ex_bus.alu_O, ex_bus.alu_S, ex_bus.alu_C, ex_bus.alu_Z} = aflags;
    ex_bus.se_out     = se;
    ex_bus.pc_link    = link;
    ex_bus.tf_out     = tf;
  endtask

  function automatic logic [31:0] flagVec();
    return {28'd0, rf_O, rf_S, rf_C, rf_Z};
  endfunction

  initial begin
    RESET = 1'b0;
    ex_bus.in_valid = 1'b0;
    ex_bus.dm_Q     = 32'd0;
    applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 5'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0);
    ex_bus.in_valid = 1'b0;
    step();
    step();
    checkOutput("reset_in_ready", 32'(ex_bus.in_ready), 32'd1);
    checkOutput("reset_rb_W", 32'(rb_W), 32'd0);
    checkOutput("reset_rb_ADDR", 32'(rb_ADDR), 32'd0);
    checkOutput("reset_rb_DATA", rb_DATA, 32'd0);
    checkOutput("reset_pc_load", 32'(pc_load), 32'd0);
    checkOutput("reset_pc_target", pc_target, 32'd0);
    checkOutput("reset_flags", flagVec(), 32'd0);
    checkOutput("reset_retired", retired, 32'd0);
    RESET = 1'b1;
    step();

    // ADD r3 = 0x2A, all flag enables, flags 0001
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b0, 5'd3, 32'h2A, 4'b0001, 32'h0, 32'h0, 1'b0);
    step();
    ex_bus.in_valid = 1'b0;
    checkOutput("add_rb_W", 32'(rb_W), 32'd1);
    checkOutput("add_rb_ADDR", 32'(rb_ADDR), 32'd3);
    checkOutput("add_rb_DATA", rb_DATA, 32'h2A);
    checkOutput("add_in_ready", 32'(ex_bus.in_ready), 32'd0);
    checkOutput("add_flags_old", flagVec(), 32'd0);
    step();
    checkOutput("add_flags_new", flagVec(), 32'b0001);
    checkOutput("add_retired", retired, 32'd1);
    checkOutput("add_rb_W_drop", 32'(rb_W), 32'd0);
    checkOutput("add_rb_DATA_hold", rb_DATA, 32'h2A);

    // Load r5 from data memory
    applyStimulus(1'b1, 2'd1, 4'b0000, 1'b0, 5'd5, 32'h40, 4'b1111, 32'h0, 32'h0, 1'b0);
    step();
    ex_bus.in_valid = 1'b0;
    checkOutput("ld_wait_ready", 32'(ex_bus.in_ready), 32'd0);
    checkOutput("ld_wait_rb_W", 32'(rb_W), 32'd0);
    ex_bus.dm_Q = 32'hDEADBEEF;
    step();
    ex_bus.dm_Q = 32'h0;
    checkOutput("ld_commit_ready", 32'(ex_bus.in_ready), 32'd0);
    checkOutput("ld_rb_W", 32'(rb_W), 32'd1);
    checkOutput("ld_rb_ADDR", 32'(rb_ADDR), 32'd5);
    checkOutput("ld_rb_DATA", rb_DATA, 32'hDEADBEEF);
    step();
    checkOutput("ld_ready_back", 32'(ex_bus.in_ready), 32'd1);
    checkOutput("ld_retired", retired, 32'd2);
    checkOutput("ld_flags_kept", flagVec(), 32'b0001);

    // Jump-and-link, taken
    applyStimulus(1'b1, 2'd2, 4'b0000, 1'b1, 5'd31, 32'h100, 4'b1111, 32'h0, 32'h21, 1'b1);
    step();
    ex_bus.in_valid = 1'b0;
    checkOutput("jal_pc_load", 32'(pc_load), 32'd1);
    checkOutput("jal_pc_target", pc_target, 32'h100);
    checkOutput("jal_rb_W", 32'(rb_W), 32'd1);
    checkOutput("jal_rb_DATA", rb_DATA, 32'h21);
    step();
    checkOutput("jal_pc_load_drop", 32'(pc_load), 32'd0);
    checkOutput("jal_pc_target_hold", pc_target, 32'h100);
    checkOutput("jal_flags_kept", flagVec(), 32'b0001);

    // Jump-and-link, not taken: link write still happens
    applyStimulus(1'b1, 2'd2, 4'b0000, 1'b1, 5'd30, 32'h200, 4'b0000, 32'h0, 32'h44, 1'b0);
    step();
    ex_bus.in_valid = 1'b0;
    checkOutput("jnt_pc_load", 32'(pc_load), 32'd0);
    checkOutput("jnt_rb_W", 32'(rb_W), 32'd1);
    checkOutput("jnt_rb_DATA", rb_DATA, 32'h44);
    step();
    checkOutput("jnt_retired", retired, 32'd4);

    // Flag isolation: set all, then clear only S
    applyStimulus(1'b0, 2'd3, 4'b1111, 1'b0, 5'd1, 32'h0, 4'b1111, 32'h55, 32'h0, 1'b0);
    step();
    ex_bus.in_valid = 1'b0;
    checkOutput("fl_nowrite_rb_W", 32'(rb_W), 32'd0);
    step();
    checkOutput("fl_all_set", flagVec(), 32'b1111);
    applyStimulus(1'b0, 2'd0, 4'b0100, 1'b0, 5'd1, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0);
    step();
    ex_bus.in_valid = 1'b0;
    step();
    checkOutput("fl_isolate", flagVec(), 32'b1011);
    checkOutput("fl_retired", retired, 32'd6);

    // Reset while in MEM_WAIT discards the pending load
    applyStimulus(1'b1, 2'd1, 4'b1111, 1'b0, 5'd7, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0);
    step();
    ex_bus.in_valid = 1'b0;
    ex_bus.dm_Q = 32'h12345678;
    RESET = 1'b0;
    #1;
    checkOutput("rst_mw_in_ready", 32'(ex_bus.in_ready), 32'd1);
    checkOutput("rst_mw_rb_W", 32'(rb_W), 32'd0);
    checkOutput("rst_mw_retired", retired, 32'd0);
    step();
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rst_mw_no_write", 32'(rb_W), 32'd0);
    end
    checkOutput("rst_mw_ready_after", 32'(ex_bus.in_ready), 32'd1);
    checkOutput("rst_mw_rb_DATA", rb_DATA, 32'd0);
    checkOutput("rst_mw_flags", flagVec(), 32'd0);
    ex_bus.dm_Q = 32'h0;

    // Retired counter wrap
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    #1;
    checkOutput("wrap_preload", retired, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b0, 5'd2, 32'h9, 4'b0000, 32'h0, 32'h0, 1'b0);
    step();
    ex_bus.in_valid = 1'b0;
    checkOutput("wrap_commit_data", rb_DATA, 32'h9);
    step();
    checkOutput("wrap_retired", retired, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
